mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single backend memory port (index/valid/ready request channel plus `operation_done` completion) between two requesters: instruction fetch (read only) and the LSU (load or store). It sits between the fetch unit / mem stage and the memory interface. It grants one transaction at a time with round-robin fairness and registers the winning request. It routes the completion and read data back to the owner, and flags a completion that never arrives.

## Interface
Parameters:
- `INDEX_WIDTH`, 64, width of the doubleword index (byte address >> 3).
- `DATA_WIDTH`, 64, read/write data width; mask is 64 bits (one per data bit).
- `TIMEOUT`, 1024, cycles in WAIT before `err_timeout` sets; must be ≥ 2.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `fetch_req_valid`  in  1  fetch read request.
- `fetch_req_ready`  out  1  fetch request accepted this cycle.
- `fetch_req_index`  in  INDEX_WIDTH  fetch doubleword index.
- `fetch_done`  out  1  one-cycle completion pulse to fetch.
- `fetch_read_data`  out  DATA_WIDTH  read data, valid with `fetch_done`.
- `lsu_req_valid`  in  1  LSU request.
- `lsu_req_ready`  out  1  LSU request accepted this cycle.
- `lsu_req_write`  in  1  1 = store, 0 = load.
- `lsu_req_index`  in  INDEX_WIDTH  LSU doubleword index.
- `lsu_req_write_data`  in  DATA_WIDTH  store data, already lane-shifted.
- `lsu_req_write_mask`  in  64  store bit mask.
- `lsu_done`  out  1  one-cycle completion pulse to LSU.
- `lsu_read_data`  out  DATA_WIDTH  load data, valid with `lsu_done`.
- `mem_index_valid`  out  1  downstream request valid.
- `mem_index_ready`  in  1  downstream accepts.
- `mem_write`  out  1  downstream request is a store.
- `mem_index`  out  INDEX_WIDTH  downstream index.
- `mem_write_data`  out  DATA_WIDTH  downstream store data.
- `mem_write_mask`  out  64  downstream store mask.
- `mem_operation_done`  in  1  downstream completion.
- `mem_read_data`  in  DATA_WIDTH  downstream read data.
- `busy`  out  1  state ≠ IDLE.
- `err_timeout`  out  1  sticky: WAIT exceeded TIMEOUT cycles.

## Operation
- States: IDLE, ISSUE, WAIT. Registers: `owner` (0 = fetch, 1 = LSU), `last_grant`, a request payload register, `wait_cnt`, `err_timeout`.
- IDLE, arbitration (combinational):
  - Only one requester valid: it wins.
  - Both valid: the winner is the requester ≠ `last_grant`.
  - Winner's `*_req_ready` = 1; the loser's ready = 0. Both readies are 0 outside IDLE.
- On accept (valid & ready):
  - Capture index, write flag, data and mask into the payload register.
  - Fetch forces write = 0 and data/mask = 0.
  - Set `owner`; go to ISSUE.
- ISSUE: `mem_index_valid` = 1 with the payload driven from registers and held stable. On `mem_index_ready`, go to WAIT and clear `wait_cnt`.
- WAIT:
  - `wait_cnt` increments each cycle and saturates.
  - On `mem_operation_done`: `<owner>_done` = 1 in that same cycle, `<owner>_read_data` = `mem_read_data` (combinational pass-through), `last_grant` ← `owner`, go to IDLE.
  - When `wait_cnt` reaches TIMEOUT-1 without done, `err_timeout` ← 1. The FSM keeps waiting; there is no abort.
- `mem_operation_done` outside WAIT is ignored and produces no `*_done`.
- `*_read_data` is 0 when the matching `*_done` is 0.
- `mem_write_data`/`mem_write_mask`/`mem_index`/`mem_write` are 0 when `mem_index_valid` = 0.
- Reset mid-transaction: abandon it, go to IDLE, produce no done pulse. Downstream must also be reset.

## Timing
- Reset values:
  - state IDLE, `last_grant` = 1 (LSU), so fetch wins the first tie.
  - All outputs 0: readies, `mem_index_valid`, `*_done`, `busy`, `err_timeout`, all data.
- Accept at cycle N → `mem_index_valid` = 1 at N+1.
- Downstream fire at F → WAIT from F+1. The earliest honoured done is F+1.
- Done at D → IDLE at D+1. A new request is accepted at D+1 and issued at D+2. Minimum request-to-request spacing is 3 cycles with zero-latency memory.
- Requester latency: accept to `*_done` ≥ 2 cycles.
- Readies are combinational from the valids and state. Requesters must hold valid and payload until ready.

## Test plan
- Single fetch:
  - Stimulus: `fetch_req_valid`=1, index 0x1000 at cycle 0; `mem_index_ready`=1 at cycle 1; done with `mem_read_data`=0xDEADBEEF at cycle 3.
  - Response: `fetch_req_ready`=1 at cycle 0; `mem_index_valid`=1 at cycle 1 with `mem_write`=0; `fetch_done`=1 with 0xDEADBEEF at cycle 3; `lsu_done`=0 throughout.
- LSU store with backpressure:
  - Stimulus: index 0x20, data 0xAB00, mask 0xFF00, write=1; `mem_index_ready` held 0 for 4 cycles.
  - Response: `mem_index_valid` and the payload are stable all 4 cycles; fire on ready; `lsu_done` on completion.
- Round-robin: both requesters valid continuously for 4 transactions after reset → grant order fetch, LSU, fetch, LSU.
- Spurious done:
  - Stimulus: `mem_operation_done`=1 while IDLE, and again in the cycle of the ISSUE fire.
  - Response: no `*_done`; state unchanged by the done.
- Timeout: TIMEOUT=8, no done after fire → `err_timeout`=1 at the 8th WAIT cycle and stays 1; a later done still returns `*_done` and IDLE.
- Reset in WAIT: assert `reset` for 1 cycle → next cycle all outputs 0 and state IDLE; a subsequent fetch request is granted first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one backend memory port between instruction fetch and the LSU.
// One transaction in flight at a time; completion and read data are routed back to the owner.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no transaction; arbitrate and accept one request
// ST_ISSUE | registered request presented downstream until ready
// ST_WAIT  | waiting for mem_operation_done; wait_cnt drives timeout flag
module mem_port_arbiter #(
  parameter int INDEX_WIDTH = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fetch_req_valid,
  output logic                   fetch_req_ready,
  input  logic [INDEX_WIDTH-1:0] fetch_req_index,
  output logic                   fetch_done,
  output logic [DATA_WIDTH-1:0]  fetch_read_data,
  input  logic                   lsu_req_valid,
  output logic                   lsu_req_ready,
  input  logic                   lsu_req_write,
  input  logic [INDEX_WIDTH-1:0] lsu_req_index,
  input  logic [DATA_WIDTH-1:0]  lsu_req_write_data,
  input  logic [63:0]            lsu_req_write_mask,
  output logic                   lsu_done,
  output logic [DATA_WIDTH-1:0]  lsu_read_data,
  output logic                   mem_index_valid,
  input  logic                   mem_index_ready,
  output logic                   mem_write,
  output logic [INDEX_WIDTH-1:0] mem_index,
  output logic [DATA_WIDTH-1:0]  mem_write_data,
  output logic [63:0]            mem_write_mask,
  input  logic                   mem_operation_done,
  input  logic [DATA_WIDTH-1:0]  mem_read_data,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Flag is registered one cycle early so it is visible in the TIMEOUT-th WAIT cycle.
  localparam logic [CNT_W-1:0] CNT_ERR = CNT_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic                   owner;
  logic                   last_grant;
  logic [INDEX_WIDTH-1:0] pay_index;
  logic                   pay_write;
  logic [DATA_WIDTH-1:0]  pay_data;
  logic [63:0]            pay_mask;
  logic [CNT_W-1:0]       wait_cnt;
  logic                   err_q;
  logic                   fetch_win;
  logic                   lsu_win;
  logic                   accept;
  logic                   done_ok;

  // On a tie the requester that did not own the previous transaction wins.
  always_comb begin
    fetch_win = fetch_req_valid && (!lsu_req_valid || last_grant);
    lsu_win   = lsu_req_valid && (!fetch_req_valid || !last_grant);
    accept    = (state == ST_IDLE) && (fetch_win || lsu_win);
    done_ok   = (state == ST_WAIT) && mem_operation_done;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_ISSUE;
      ST_ISSUE: if (mem_index_ready) state_next = ST_WAIT;
      ST_WAIT:  if (mem_operation_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    fetch_req_ready = (state == ST_IDLE) && fetch_win;
    lsu_req_ready   = (state == ST_IDLE) && lsu_win;
    mem_index_valid = (state == ST_ISSUE);
    mem_write       = mem_index_valid && pay_write;
    mem_index       = mem_index_valid ? pay_index : '0;
    mem_write_data  = mem_index_valid ? pay_data : '0;
    mem_write_mask  = mem_index_valid ? pay_mask : '0;
    fetch_done      = done_ok && !owner;
    lsu_done        = done_ok && owner;
    fetch_read_data = fetch_done ? mem_read_data : '0;
    lsu_read_data   = lsu_done ? mem_read_data : '0;
    busy            = (state != ST_IDLE);
    err_timeout     = err_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      pay_index  <= '0;
      pay_write  <= 1'b0;
      pay_data   <= '0;
      pay_mask   <= '0;
      wait_cnt   <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        owner <= !fetch_win;
        if (fetch_win) begin
          pay_index <= fetch_req_index;
          pay_write <= 1'b0;
          pay_data  <= '0;
          pay_mask  <= '0;
        end else begin
          pay_index <= lsu_req_index;
          pay_write <= lsu_req_write;
          pay_data  <= lsu_req_write_data;
          pay_mask  <= lsu_req_write_mask;
        end
      end
      if (state == ST_ISSUE && mem_index_ready) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT && wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (state == ST_WAIT && !mem_operation_done && wait_cnt == CNT_ERR) begin
        err_q <= 1'b1;
      end
      if (done_ok) begin
        last_grant <= owner;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_req_valid, fetch_req_ready, fetch_done;
  logic [63:0] fetch_req_index, fetch_read_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_write, lsu_done;
  logic [63:0] lsu_req_index, lsu_req_write_data, lsu_req_write_mask, lsu_read_data;
  logic        mem_index_valid, mem_index_ready, mem_write, mem_operation_done;
  logic [63:0] mem_index, mem_write_data, mem_write_mask, mem_read_data;
  logic        busy, err_timeout;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.INDEX_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_req_index(fetch_req_index), .fetch_done(fetch_done),
    .fetch_read_data(fetch_read_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_write(lsu_req_write), .lsu_req_index(lsu_req_index),
    .lsu_req_write_data(lsu_req_write_data), .lsu_req_write_mask(lsu_req_write_mask),
    .lsu_done(lsu_done), .lsu_read_data(lsu_read_data),
    .mem_index_valid(mem_index_valid), .mem_index_ready(mem_index_ready),
    .mem_write(mem_write), .mem_index(mem_index), .mem_write_data(mem_write_data),
    .mem_write_mask(mem_write_mask), .mem_operation_done(mem_operation_done),
    .mem_read_data(mem_read_data), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        fv;
    logic [63:0] fidx;
    logic        lv;
    logic [63:0] lidx;
    logic        mir;
    logic        md;
    logic [63:0] mrd;
    logic        e_fr, e_lr, e_miv;
    logic [63:0] e_midx;
    logic        e_fd, e_ld;
    logic [63:0] e_rd;
    logic        e_busy;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic fv, logic [63:0] fidx, logic lv, logic [63:0] lidx,
                              logic mir, logic md, logic [63:0] mrd, logic e_fr, logic e_lr,
                              logic e_miv, logic [63:0] e_midx, logic e_fd, logic e_ld,
                              logic [63:0] e_rd, logic e_busy);
    vec_t v;
    v.fv = fv; v.fidx = fidx; v.lv = lv; v.lidx = lidx; v.mir = mir; v.md = md; v.mrd = mrd;
    v.e_fr = e_fr; v.e_lr = e_lr; v.e_miv = e_miv; v.e_midx = e_midx;
    v.e_fd = e_fd; v.e_ld = e_ld; v.e_rd = e_rd; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_req_valid = 0; fetch_req_index = 0;
    lsu_req_valid = 0; lsu_req_write = 0; lsu_req_index = 0;
    lsu_req_write_data = 0; lsu_req_write_mask = 0;
    mem_index_ready = 0; mem_operation_done = 0; mem_read_data = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    #1;
  endtask

  // Reference model: transaction phase 0=idle, 1=presented downstream, 2=awaiting completion.
  int          m_phase, m_waited;
  bit          m_owner, m_last, m_err, m_w;
  logic [63:0] m_idx, m_wd, m_wm;
  bit          x_fr, x_lr, x_fd, x_ld, x_err;

  task automatic model_reset();
    m_phase = 0; m_waited = 0; m_owner = 0; m_last = 1; m_err = 0;
    m_w = 0; m_idx = 0; m_wd = 0; m_wm = 0;
  endtask

  function automatic logic [299:0] model_expect();
    bit miv;
    x_fr  = (m_phase == 0) && fetch_req_valid && (!lsu_req_valid || m_last);
    x_lr  = (m_phase == 0) && lsu_req_valid && (!fetch_req_valid || !m_last);
    miv   = (m_phase == 1);
    x_fd  = (m_phase == 2) && mem_operation_done && !m_owner;
    x_ld  = (m_phase == 2) && mem_operation_done && m_owner;
    x_err = m_err || (m_phase == 2 && m_waited >= TO);
    return {x_fr, x_lr, miv, miv && m_w, miv ? m_idx : 64'd0, miv ? m_wd : 64'd0,
            miv ? m_wm : 64'd0, x_fd, x_fd ? mem_read_data : 64'd0,
            x_ld, x_ld ? mem_read_data : 64'd0, m_phase != 0, x_err};
  endfunction

  task automatic model_step(input bit rst);
    if (rst) begin
      model_reset();
      return;
    end
    if (x_err) m_err = 1;
    if (m_phase == 0) begin
      if (x_fr) begin
        m_phase = 1; m_owner = 0; m_idx = fetch_req_index; m_w = 0; m_wd = 0; m_wm = 0;
      end else if (x_lr) begin
        m_phase = 1; m_owner = 1; m_idx = lsu_req_index; m_w = lsu_req_write;
        m_wd = lsu_req_write_data; m_wm = lsu_req_write_mask;
      end
    end else if (m_phase == 1) begin
      if (mem_index_ready) begin
        m_phase = 2; m_waited = 1;
      end
    end else begin
      if (mem_operation_done) begin
        m_last = m_owner; m_phase = 0;
      end else begin
        m_waited++;
      end
    end
  endtask

  function automatic logic [299:0] dut_outputs();
    return {fetch_req_ready, lsu_req_ready, mem_index_valid, mem_write, mem_index,
            mem_write_data, mem_write_mask, fetch_done, fetch_read_data,
            lsu_done, lsu_read_data, busy, err_timeout};
  endfunction

  initial begin
    int grants[$];
    int gcyc[$];
    int cyc;
    bit rst_now;

    tbl[0]  = mk(1, 64'h1000, 0, 0,     0, 0, 0,            1, 0, 0, 0,      0, 0, 0,            0);
    tbl[1]  = mk(0, 0,        0, 0,     1, 0, 0,            0, 0, 1, 64'h1000, 0, 0, 0,          1);
    tbl[2]  = mk(0, 0,        0, 0,     0, 0, 0,            0, 0, 0, 0,      0, 0, 0,            1);
    tbl[3]  = mk(0, 0,        0, 0,     0, 1, 64'hDEADBEEF, 0, 0, 0, 0,      1, 0, 64'hDEADBEEF, 1);
    tbl[4]  = mk(0, 0,        0, 0,     0, 0, 0,            0, 0, 0, 0,      0, 0, 0,            0);
    tbl[5]  = mk(0, 0,        1, 64'h40, 0, 0, 0,           0, 1, 0, 0,      0, 0, 0,            0);
    tbl[6]  = mk(0, 0,        0, 0,     1, 0, 0,            0, 0, 1, 64'h40, 0, 0, 0,            1);
    tbl[7]  = mk(0, 0,        0, 0,     0, 1, 64'h55,       0, 0, 0, 0,      0, 1, 64'h55,       1);
    tbl[8]  = mk(0, 0,        0, 0,     0, 1, 64'h99,       0, 0, 0, 0,      0, 0, 0,            0);
    tbl[9]  = mk(1, 64'h8,    0, 0,     0, 1, 64'h99,       1, 0, 0, 0,      0, 0, 0,            0);
    tbl[10] = mk(0, 0,        0, 0,     1, 1, 64'h99,       0, 0, 1, 64'h8,  0, 0, 0,            1);
    tbl[11] = mk(0, 0,        0, 0,     0, 0, 0,            0, 0, 0, 0,      0, 0, 0,            1);
    tbl[12] = mk(0, 0,        0, 0,     0, 1, 64'h7,        0, 0, 0, 0,      1, 0, 64'h7,        1);
    tbl[13] = mk(1, 64'h10,   1, 64'h50, 0, 0, 0,           0, 1, 0, 0,      0, 0, 0,            0);
    tbl[14] = mk(1, 64'h10,   0, 0,     0, 0, 0,            0, 0, 1, 64'h50, 0, 0, 0,            1);
    tbl[15] = mk(1, 64'h10,   0, 0,     1, 0, 0,            0, 0, 1, 64'h50, 0, 0, 0,            1);
    tbl[16] = mk(1, 64'h10,   0, 0,     0, 1, 64'h3,        0, 0, 0, 0,      0, 1, 64'h3,        1);
    tbl[17] = mk(1, 64'h10,   0, 0,     0, 0, 0,            1, 0, 0, 0,      0, 0, 0,            0);
    tbl[18] = mk(0, 0,        0, 0,     1, 0, 0,            0, 0, 1, 64'h10, 0, 0, 0,            1);
    tbl[19] = mk(0, 0,        0, 0,     0, 1, 64'h1,        0, 0, 0, 0,      1, 0, 64'h1,        1);
    tbl[20] = mk(0, 0,        0, 0,     0, 0, 0,            0, 0, 0, 0,      0, 0, 0,            0);

    do_reset();
    check("reset_outputs", dut_outputs(), 300'd0);

    for (int i = 0; i < 21; i++) begin
      fetch_req_valid = tbl[i].fv; fetch_req_index = tbl[i].fidx;
      lsu_req_valid = tbl[i].lv; lsu_req_index = tbl[i].lidx; lsu_req_write = 0;
      mem_index_ready = tbl[i].mir; mem_operation_done = tbl[i].md; mem_read_data = tbl[i].mrd;
      #1;
      check($sformatf("tbl%0d_fready", i), fetch_req_ready, tbl[i].e_fr);
      check($sformatf("tbl%0d_lready", i), lsu_req_ready, tbl[i].e_lr);
      check($sformatf("tbl%0d_mvalid", i), mem_index_valid, tbl[i].e_miv);
      check($sformatf("tbl%0d_mindex", i), mem_index, tbl[i].e_midx);
      check($sformatf("tbl%0d_mwrite", i), mem_write, 1'b0);
      check($sformatf("tbl%0d_fdone", i), {fetch_done, fetch_read_data},
            {tbl[i].e_fd, tbl[i].e_fd ? tbl[i].e_rd : 64'd0});
      check($sformatf("tbl%0d_ldone", i), {lsu_done, lsu_read_data},
            {tbl[i].e_ld, tbl[i].e_ld ? tbl[i].e_rd : 64'd0});
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      next_cycle();
    end

    // Round robin with both requesters always valid and a zero-latency memory
    do_reset();
    fetch_req_valid = 1; fetch_req_index = 64'hF0;
    lsu_req_valid = 1; lsu_req_index = 64'hE0;
    mem_index_ready = 1; mem_operation_done = 1;
    cyc = 0;
    while (grants.size() < 4 && cyc < 40) begin
      #1;
      if (fetch_req_ready && lsu_req_ready) check("rr_both_ready", 2'b11, 2'b10);
      if (fetch_req_ready) begin grants.push_back(0); gcyc.push_back(cyc); end
      else if (lsu_req_ready) begin grants.push_back(1); gcyc.push_back(cyc); end
      next_cycle();
      cyc++;
    end
    check("rr_grant_count", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++) begin
      check($sformatf("rr_grant%0d", i), grants[i], i % 2);
      if (i > 0) check($sformatf("rr_spacing%0d", i), gcyc[i] - gcyc[i-1], 3);
    end

    // LSU store held off by downstream backpressure
    do_reset();
    lsu_req_valid = 1; lsu_req_write = 1; lsu_req_index = 64'h20;
    lsu_req_write_data = 64'hAB00; lsu_req_write_mask = 64'hFF00;
    #1 check("bp_lready", lsu_req_ready, 1'b1);
    next_cycle();
    lsu_req_valid = 0; lsu_req_write = 0; lsu_req_index = 0;
    lsu_req_write_data = 0; lsu_req_write_mask = 0;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("bp_hold%0d", k),
               {mem_index_valid, mem_write, mem_index, mem_write_data, mem_write_mask},
               {1'b1, 1'b1, 64'h20, 64'hAB00, 64'hFF00});
      next_cycle();
    end
    mem_index_ready = 1;
    #1 check("bp_fire", {mem_index_valid, mem_write, mem_index}, {1'b1, 1'b1, 64'h20});
    next_cycle();
    mem_index_ready = 0;
    #1 check("bp_wait_zeroed", {mem_index_valid, mem_write, mem_write_data, mem_write_mask, busy},
             {1'b0, 1'b0, 64'd0, 64'd0, 1'b1});
    next_cycle();
    mem_operation_done = 1; mem_read_data = 64'h1234;
    #1 check("bp_done", {lsu_done, lsu_read_data, fetch_done}, {1'b1, 64'h1234, 1'b0});
    next_cycle();
    clear_inputs();

    // Timeout flag in the TO-th wait cycle, sticky, and a late done still completes
    do_reset();
    fetch_req_valid = 1; fetch_req_index = 64'h30;
    next_cycle();
    fetch_req_valid = 0; mem_index_ready = 1;
    next_cycle();
    mem_index_ready = 0;
    for (int k = 1; k <= TO + 3; k++) begin
      #1 check($sformatf("to_wait%0d", k), {busy, err_timeout}, {1'b1, k >= TO});
      next_cycle();
    end
    mem_operation_done = 1; mem_read_data = 64'hCAFE;
    #1 check("to_late_done", {fetch_done, fetch_read_data, err_timeout}, {1'b1, 64'hCAFE, 1'b1});
    next_cycle();
    mem_operation_done = 0;
    #1 check("to_idle_sticky", {busy, err_timeout}, 2'b01);

    // Reset while waiting abandons the transaction
    fetch_req_valid = 1; fetch_req_index = 64'h38;
    next_cycle();
    fetch_req_valid = 0; mem_index_ready = 1;
    next_cycle();
    mem_index_ready = 0;
    #1 check("rw_in_wait", busy, 1'b1);
    reset = 1;
    next_cycle();
    reset = 0;
    #1 check("rw_outputs_zero", dut_outputs(), 300'd0);
    mem_operation_done = 1; mem_read_data = 64'h77;
    #1 check("rw_no_done", {fetch_done, lsu_done, busy}, 3'b000);
    next_cycle();
    mem_operation_done = 0;
    fetch_req_valid = 1; lsu_req_valid = 1;
    #1 check("rw_fetch_first", {fetch_req_ready, lsu_req_ready}, 2'b10);
    next_cycle();

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      rst_now = ($urandom_range(0, 299) == 0);
      if (!fetch_req_valid && $urandom_range(0, 2) == 0) begin
        fetch_req_valid = 1; fetch_req_index = {$urandom, $urandom};
      end
      if (!lsu_req_valid && $urandom_range(0, 2) == 0) begin
        lsu_req_valid = 1; lsu_req_index = {$urandom, $urandom};
        lsu_req_write = $urandom_range(0, 1);
        lsu_req_write_data = {$urandom, $urandom}; lsu_req_write_mask = {$urandom, $urandom};
      end
      mem_index_ready = ($urandom_range(0, 2) != 0);
      mem_operation_done = ($urandom_range(0, 3) == 0);
      mem_read_data = {$urandom, $urandom};
      reset = rst_now;
      #1 check($sformatf("rand%0d", c), dut_outputs(), model_expect());
      model_step(rst_now);
      next_cycle();
      reset = 0;
      if (rst_now || x_fr) fetch_req_valid = 0;
      if (rst_now || x_lr) lsu_req_valid = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
